// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, funct, FSM state and ALU-op definitions for the multicycle core
package cpu_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;
  localparam logic [2:0] OP_RSVD  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] FUNCT_ADD = 2'b00;
  localparam logic [1:0] FUNCT_SUB = 2'b01;
  localparam logic [1:0] FUNCT_AND = 2'b10;
  localparam logic [1:0] FUNCT_OR  = 2'b11;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  function automatic alu_op_e funct_to_alu(input logic [1:0] funct);
    case (funct)
      FUNCT_SUB: return ALU_SUB;
      FUNCT_AND: return ALU_AND;
      FUNCT_OR:  return ALU_OR;
      default:   return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - four-entry register file, two read ports, one write port, R0 reads zero
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  logic [DATA_W-1:0] regs [0:3];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we && (waddr != 2'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multicycle 16-bit-instruction core: FSM, ALU and datapath latches
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc
);

  state_e            state, state_nx;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              illegal_q;

  logic [2:0]        opcode;
  logic [1:0]        rs, rt, rd, funct;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a, jtarget;

  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b, alu_y;

  logic              rf_we;
  logic [1:0]        rf_waddr;

  assign opcode  = ir[15:13];
  assign rs      = ir[12:11];
  assign rt      = ir[10:9];
  assign rd      = ir[8:7];
  assign funct   = ir[1:0];
  assign imm_d   = DATA_W'($signed(ir[7:0]));
  assign imm_a   = ADDR_W'($signed(ir[7:0]));
  assign jtarget = ADDR_W'(ir[12:0]);

  cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .Clock   (Clock),
    .Reset   (Reset),
    .raddr_a (rs),
    .rdata_a (rd_a),
    .raddr_b (rt),
    .rdata_b (rd_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (res_q)
  );

  // R-type uses funct; ADDI and LW/SW address generation share the adder.
  always_comb begin
    alu_op = (opcode == OP_RTYPE) ? funct_to_alu(funct) : ALU_ADD;
    alu_b  = (opcode == OP_RTYPE) ? b_q : imm_d;
    alu_y  = '0;
    case (alu_op)
      ALU_ADD: alu_y = a_q + alu_b;
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_nx = DECODE;
      end
      DECODE: begin
        if (opcode == OP_HALT || opcode == OP_RSVD) state_nx = HALT;
        else                                        state_nx = EXEC;
      end
      EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: state_nx = WB;
          OP_LW, OP_SW:      state_nx = MEM;
          default:           state_nx = FETCH;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = (opcode == OP_SW);
        mem_addr = ADDR_W'(res_q);
        if (mem_ready) state_nx = (opcode == OP_LW) ? WB : FETCH;
      end
      WB: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
        state_nx = FETCH;
      end
      HALT: state_nx = HALT;
      default: state_nx = FETCH;
    endcase
    // The bus stays idle for as long as Reset is held, even in the FETCH it forces.
    if (Reset) begin
      mem_req = 1'b0;
      rf_we   = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q      <= ADDR_W'(RESET_PC);
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir   <= mem_rdata[15:0];
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
          if (opcode == OP_RSVD) illegal_q <= 1'b1;
        end
        EXEC: begin
          case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW: res_q <= alu_y;
            OP_BEQ: if (a_q == b_q) pc_q <= pc_q + imm_a;
            OP_J:   pc_q <= jtarget;
            default: ;
          endcase
        end
        MEM: begin
          if (mem_ready && opcode == OP_LW) res_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_wdata = b_q;
  assign halted    = (state == HALT);
  assign illegal   = illegal_q;
  assign pc        = pc_q;

endmodule
